// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame data width.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte stream from uart_rx to the download RAM packer.
interface uart_rx_if;
    import uart_pkg::*;

    logic                      rx_valid;
    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      o_frame_err;
    logic                      o_parity_err;
    logic                      o_busy;

    modport master (
        output rx_valid,
        output rx_data,
        output o_frame_err,
        output o_parity_err,
        output o_busy
    );

    modport slave (
        input rx_valid,
        input rx_data,
        input o_frame_err,
        input o_parity_err,
        input o_busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver producing single-cycle byte strobes.
// Define UART_PARITY_EN to receive an even-parity bit before the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic i_reset_n,
    input  logic i_rx,
    uart_rx_if.master rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    state_t                    state;
    logic [CW-1:0]             timer;
    logic [2:0]                idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      rx_s;
    logic                      rx_q;
    logic                      valid_q;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      ferr_q;
    logic                      perr_q;
    logic                      busy_q;
`ifdef UART_PARITY_EN
    logic                      par_bad;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (i_reset_n),
        .d     (i_rx),
        .q     (rx_s)
    );

    wire tick = (timer == BIT_END);
    wire half = (timer == HALF_END);

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            timer   <= '0;
            idx     <= '0;
            shreg   <= '0;
            rx_q    <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            rx_q    <= rx_s;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Edge, not level: a held-low break cannot retrigger.
                    if (rx_q && !rx_s) begin
                        state  <= START;
                        timer  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (half) begin
                        timer <= '0;
                        idx   <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        timer <= '0;
                        shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        idx   <= idx + 3'd1;
                        if (idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end
                PARITY: begin
`ifdef UART_PARITY_EN
                    if (tick) begin
                        timer   <= '0;
                        par_bad <= rx_s ^ (^shreg);
                        state   <= STOP;
                    end else begin
                        timer <= timer + CW'(1);
                    end
`else
                    state  <= IDLE;
                    busy_q <= 1'b0;
`endif
                end
                STOP: begin
                    if (tick) begin
                        timer  <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (!rx_s) begin
                            ferr_q <= 1'b1;
                        end
`ifdef UART_PARITY_EN
                        else if (par_bad) begin
                            perr_q <= 1'b1;
                        end
`endif
                        else begin
                            valid_q <= 1'b1;
                            data_q  <= shreg;
                        end
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.rx_valid     = valid_q;
    assign rx.rx_data      = data_q;
    assign rx.o_frame_err  = ferr_q;
    assign rx.o_parity_err = perr_q;
    assign rx.o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus corner sequences.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
    localparam int LAT   = 2 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int NBITS = 10;
    localparam int LAT   = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_PERR  = 3'b001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_line = 1'b1;

    always #5 clk = ~clk;

    uart_rx_if rxif ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .i_reset_n (rst_n),
        .i_rx      (rx_line),
        .rx        (rxif)
    );

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par_ok;
    } vec_t;

    exp_t   sb[$];
    longint vcyc[$];
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    logic [7:0] last_good = 8'h00;
    logic [2:0] mon_kind;
    exp_t   mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            mon_kind = {rxif.rx_valid, rxif.o_frame_err, rxif.o_parity_err};
            if (mon_kind != 3'b000) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe: got kind=%b data=%h, required none",
                             mon_kind, rxif.rx_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_kind !== mon_e.kind || rxif.rx_data !== mon_e.data) begin
                        failures++;
                        $display("FAIL strobe: got kind=%b data=%h, required kind=%b data=%h",
                                 mon_kind, rxif.rx_data, mon_e.kind, mon_e.data);
                    end
                end
                if (mon_kind == K_VALID) vcyc.push_back(cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic [2:0] kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = (kind == K_VALID) ? d : last_good;
        if (kind == K_VALID) last_good = d;
        sb.push_back(e);
    endtask

    task automatic drive_bit(input logic b);
        rx_line = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit(par_ok ? ^d : ~^d);
`endif
        drive_bit(stop);
        rx_line = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s: got %0d pending events, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1};
        vecs[1] = '{8'h3C, 1'b1, 1'b1};
        vecs[2] = '{8'h5A, 1'b1, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 1'b1};
        vecs[4] = '{8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFE, 1'b1, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", rxif.rx_valid, 0);
        chk("rst_data", rxif.rx_data, 0);
        chk("rst_ferr", rxif.o_frame_err, 0);
        chk("rst_perr", rxif.o_parity_err, 0);
        chk("rst_busy", rxif.o_busy, 0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            longint t0;
            vcyc.delete();
            expect_ev(K_VALID, vecs[i].data);
            t0 = cyc;
            send(vecs[i].data, vecs[i].stop, vecs[i].par_ok);
            repeat (2 * CPB) @(negedge clk);
            drain("vec_drain");
            chk("vec_busy", rxif.o_busy, 0);
            chk("vec_npulses", vcyc.size(), 1);
            if (vcyc.size() == 1) begin
                checks++;
                if (vcyc[0] - t0 < LAT - 1 || vcyc[0] - t0 > LAT + 1) begin
                    failures++;
                    $display("FAIL latency: got %0d, required %0d+-1", vcyc[0] - t0, LAT);
                end
            end
        end

        vcyc.delete();
        expect_ev(K_VALID, 8'h00);
        expect_ev(K_VALID, 8'hFF);
        send(8'h00, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        drain("b2b_drain");
        chk("b2b_npulses", vcyc.size(), 2);
        if (vcyc.size() == 2)
            chk("b2b_spacing", vcyc[1] - vcyc[0], NBITS * CPB);

        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch_busy_mid", rxif.o_busy, 1);
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_busy", rxif.o_busy, 0);
        expect_ev(K_VALID, 8'h3C);
        send(8'h3C, 1'b1, 1'b1);
        repeat (CPB) @(negedge clk);
        drain("glitch_drain");

        expect_ev(K_FERR, 8'h55);
        send(8'h55, 1'b0, 1'b1);
        rx_line = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        drain("break_drain");
        chk("break_data", rxif.rx_data, 8'h3C);
        chk("break_busy", rxif.o_busy, 0);
        rx_line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        expect_ev(K_VALID, 8'h12);
        send(8'h12, 1'b1, 1'b1);
        repeat (CPB) @(negedge clk);
        drain("after_break_drain");

        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i == 0);
        rx_line = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", rxif.rx_valid, 0);
        chk("midrst_data", rxif.rx_data, 0);
        chk("midrst_busy", rxif.o_busy, 0);
        rx_line = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_good = 8'h00;
        repeat (20 * CPB) @(negedge clk);
        chk("midrst_idle_busy", rxif.o_busy, 0);
        expect_ev(K_VALID, 8'h81);
        send(8'h81, 1'b1, 1'b1);
        repeat (CPB) @(negedge clk);
        drain("midrst_drain");

`ifdef UART_PARITY_EN
        expect_ev(K_VALID, 8'h07);
        send(8'h07, 1'b1, 1'b1);
        repeat (CPB) @(negedge clk);
        drain("par_good_drain");
        expect_ev(K_PERR, 8'h07);
        send(8'h07, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);
        drain("par_bad_drain");
        chk("par_bad_data", rxif.rx_data, 8'h07);
`else
        chk("perr_tied", rxif.o_parity_err, 0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
